// File: rtl/pwm_capture_pkg.sv
// ============================================================================
// Module      : pwm_capture_pkg
// Description : Shared types and constants for the PWM capture block.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pwm_capture_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    localparam int ST_MEAS  = 0;
    localparam int ST_STALL = 1;

endpackage

`default_nettype wire

// File: rtl/pwm_capture_edge_sync.sv
// ============================================================================
// Module      : edge_sync
// Description : Multi-flop synchronizer followed by a rise/fall edge detector.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    // Edges are suppressed until the pipeline holds only post-reset samples,
    // so a line already high at reset release never looks like a rising edge.
    logic [SYNC_STAGES:0]   r_fill;
    logic                   w_armed;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
            r_fill <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], d_i};
            r_prev <= r_sync[SYNC_STAGES-1];
            r_fill <= {r_fill[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign w_armed = r_fill[SYNC_STAGES];
    assign level_o = r_sync[SYNC_STAGES-1];
    assign rise_o  = w_armed &  r_sync[SYNC_STAGES-1] & ~r_prev;
    assign fall_o  = w_armed & ~r_sync[SYNC_STAGES-1] &  r_prev;

endmodule

`default_nettype wire

// File: rtl/pwm_capture.sv
// ============================================================================
// Module      : pwm_capture
// Description : Measures PWM period and high time in clk cycles, with sticky
//               measurement/stall status and a level interrupt.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_capture
    import pwm_capture_pkg::*;
#(
    parameter int COUNT_W     = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en_i,
    input  logic               pwm_i,
    input  logic [1:0]         irq_en_i,
    input  logic [1:0]         irq_clr_i,
    output logic [COUNT_W-1:0] period_o,
    output logic [COUNT_W-1:0] high_o,
    output logic               valid_o,
    output logic               capture_o,
    output logic               stall_o,
    output logic [1:0]         status_o,
    output logic               irq
);

    localparam logic [COUNT_W-1:0] c_cnt_max = '1;

    logic               w_level_unused;
    logic               w_rise;
    logic               w_fall;
    logic               w_sat;
    state_t             r_state;
    state_t             w_next_state;
    logic [COUNT_W-1:0] r_cnt;
    logic [COUNT_W-1:0] r_high_cnt;
    logic [COUNT_W-1:0] r_period;
    logic [COUNT_W-1:0] r_high;
    logic               r_valid;
    logic               r_stall;
    logic [1:0]         r_status;
    logic               r_irq;
    logic [1:0]         w_set;
    logic [1:0]         w_next_status;
    logic               w_cnt_clr;
    logic               w_cnt_load1;
    logic               w_cnt_inc;
    logic               w_take_high;
    logic               w_report;
    logic               w_stall;

    edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_edge_sync (
        .clk     (clk),
        .rst     (rst),
        .d_i     (pwm_i),
        .level_o (w_level_unused),
        .rise_o  (w_rise),
        .fall_o  (w_fall)
    );

    // Saturation takes priority over any edge seen in the same cycle.
    assign w_sat = (r_state != IDLE) && (r_cnt == c_cnt_max);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (!en_i) begin
            w_next_state = IDLE;
        end else begin
            case (r_state)
                IDLE: if (w_rise) w_next_state = HIGH;
                HIGH: begin
                    if (w_sat)       w_next_state = IDLE;
                    else if (w_fall) w_next_state = LOW;
                end
                LOW: begin
                    if (w_sat)       w_next_state = IDLE;
                    else if (w_rise) w_next_state = HIGH;
                end
                default: w_next_state = IDLE;
            endcase
        end
    end

    always_comb begin
        w_cnt_clr   = 1'b0;
        w_cnt_load1 = 1'b0;
        w_cnt_inc   = 1'b0;
        w_take_high = 1'b0;
        w_report    = 1'b0;
        w_stall     = 1'b0;
        if (!en_i) begin
            w_cnt_clr = 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_rise) w_cnt_load1 = 1'b1;
                    else        w_cnt_clr   = 1'b1;
                end
                HIGH: begin
                    if (w_sat) begin
                        w_stall   = 1'b1;
                        w_cnt_clr = 1'b1;
                    end else begin
                        w_cnt_inc   = 1'b1;
                        w_take_high = w_fall;
                    end
                end
                LOW: begin
                    if (w_sat) begin
                        w_stall   = 1'b1;
                        w_cnt_clr = 1'b1;
                    end else if (w_rise) begin
                        w_report    = 1'b1;
                        w_cnt_load1 = 1'b1;
                    end else begin
                        w_cnt_inc = 1'b1;
                    end
                end
                default: w_cnt_clr = 1'b1;
            endcase
        end
    end

    // A set and a clear landing together leave the status bit set.
    always_comb begin
        w_set           = 2'b00;
        w_set[ST_MEAS]  = r_valid;
        w_set[ST_STALL] = r_stall;
        w_next_status   = (r_status & ~irq_clr_i) | w_set;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_high_cnt <= '0;
            r_period   <= '0;
            r_high     <= '0;
            r_valid    <= 1'b0;
            r_stall    <= 1'b0;
            r_status   <= 2'b00;
            r_irq      <= 1'b0;
        end else begin
            if (w_cnt_clr)        r_cnt <= '0;
            else if (w_cnt_load1) r_cnt <= {{(COUNT_W-1){1'b0}}, 1'b1};
            else if (w_cnt_inc)   r_cnt <= r_cnt + 1'b1;
            if (w_take_high) r_high_cnt <= r_cnt;
            if (w_report) begin
                r_period <= r_cnt;
                r_high   <= r_high_cnt;
            end
            r_valid  <= w_report;
            r_stall  <= w_stall;
            r_status <= w_next_status;
            r_irq    <= |(w_next_status & irq_en_i);
        end
    end

    assign period_o  = r_period;
    assign high_o    = r_high;
    assign valid_o   = r_valid;
    assign capture_o = r_valid;
    assign stall_o   = r_stall;
    assign status_o  = r_status;
    assign irq       = r_irq;

endmodule

`default_nettype wire

// File: tb/tb_pwm_capture.sv
// ============================================================================
// Module      : tb_pwm_capture
// Description : Self-checking bench for pwm_capture with a result scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pwm_capture;

    localparam int SYNC = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        pwm = 1'b0;
    logic        pwm8 = 1'b0;
    logic [1:0]  irq_en = 2'b00;
    logic [1:0]  irq_clr = 2'b00;

    logic [15:0] period_o, high_o;
    logic        valid_o, capture_o, stall_o, irq;
    logic [1:0]  status_o;
    logic [7:0]  period8, high8;
    logic        valid8, capture8, stall8, irq8;
    logic [1:0]  status8;

    pwm_capture #(.COUNT_W(16), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .rst(rst), .en_i(en), .pwm_i(pwm), .irq_en_i(irq_en),
        .irq_clr_i(irq_clr), .period_o(period_o), .high_o(high_o),
        .valid_o(valid_o), .capture_o(capture_o), .stall_o(stall_o),
        .status_o(status_o), .irq(irq)
    );

    pwm_capture #(.COUNT_W(8), .SYNC_STAGES(SYNC)) dut8 (
        .clk(clk), .rst(rst), .en_i(en), .pwm_i(pwm8), .irq_en_i(irq_en),
        .irq_clr_i(irq_clr), .period_o(period8), .high_o(high8),
        .valid_o(valid8), .capture_o(capture8), .stall_o(stall8),
        .status_o(status8), .irq(irq8)
    );

    always #5 clk = ~clk;

    typedef struct { int p; int h; } exp_t;
    exp_t sb[$];
    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    int n_valid = 0;
    int last_vcyc = 0;
    int last_gap = 0;

    always @(posedge clk) cyc++;

    // Scoreboard consumer: every report must match the oldest pending period.
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst) begin
            if (valid_o || capture_o) begin
                tests_run++;
                if (capture_o !== valid_o) begin
                    tests_failed++;
                    $display("FAIL capture_align: capture_o=%b valid_o=%b", capture_o, valid_o);
                end
            end
            if (valid_o === 1'b1) begin
                n_valid++;
                if (last_vcyc > 0) last_gap = cyc - last_vcyc;
                last_vcyc = cyc;
                tests_run++;
                if (sb.size() == 0) begin
                    tests_failed++;
                    $display("FAIL unexpected_valid: period_o=%0d high_o=%0d, none expected", period_o, high_o);
                end else begin
                    e = sb.pop_front();
                    if (period_o !== 16'(e.p) || high_o !== 16'(e.h)) begin
                        tests_failed++;
                        $display("FAIL report: got %0d/%0d want %0d/%0d", period_o, high_o, e.p, e.h);
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input logic lvl, input int n);
        pwm = lvl;
        tick(n);
    endtask

    task automatic gen(input int p, input int h, input int rises);
        for (int i = 0; i < rises; i++) begin
            if (i > 0) sb.push_back('{p, h});
            drive(1'b1, h);
            drive(1'b0, p - h);
        end
    endtask

    task automatic settle();
        tick(SYNC + 4);
        tests_run++;
        if (sb.size() != 0) begin
            tests_failed++;
            $display("FAIL sb_drain: %0d reports missing, want 0", sb.size());
            sb.delete();
        end
        en = 1'b0;
        tick(2);
        en = 1'b1;
        tick(2);
    endtask

    task automatic test_reset();
        tick(3);
        tests_run++;
        if ({period_o, high_o, valid_o, capture_o, stall_o, status_o, irq} !== 39'd0) begin
            tests_failed++;
            $display("FAIL reset16: p=%0d h=%0d v=%b c=%b s=%b st=%b irq=%b, want all 0",
                     period_o, high_o, valid_o, capture_o, stall_o, status_o, irq);
        end
        tests_run++;
        if ({period8, high8, valid8, capture8, stall8, status8, irq8} !== 23'd0) begin
            tests_failed++;
            $display("FAIL reset8: p=%0d h=%0d st=%b irq=%b, want all 0", period8, high8, status8, irq8);
        end
        rst = 1'b0;
        tick(SYNC + 3);
    endtask

    task automatic test_basic();
        int nv0;
        irq_en = 2'b01;
        en = 1'b1;
        tick(2);
        last_vcyc = 0;
        nv0 = n_valid;
        gen(100, 25, 5);
        tests_run++;
        if (n_valid - nv0 != 4) begin
            tests_failed++;
            $display("FAIL basic_count: got %0d reports want 4", n_valid - nv0);
        end
        tests_run++;
        if (last_gap != 100) begin
            tests_failed++;
            $display("FAIL basic_gap: got %0d cycles want 100", last_gap);
        end
        tests_run++;
        if (status_o !== 2'b01 || irq !== 1'b1) begin
            tests_failed++;
            $display("FAIL basic_status: status=%b irq=%b want 01/1", status_o, irq);
        end
        settle();
    endtask

    task automatic test_duty();
        int nv0;
        for (int k = 0; k < 2; k++) begin
            nv0 = n_valid;
            gen(10, (k == 0) ? 1 : 9, 5);
            tests_run++;
            if (n_valid - nv0 != 4) begin
                tests_failed++;
                $display("FAIL duty_count: got %0d reports want 4", n_valid - nv0);
            end
            settle();
        end
    endtask

    task automatic test_clr();
        irq_clr = 2'b01;
        tick(1);
        irq_clr = 2'b00;
        tests_run++;
        if (status_o[0] !== 1'b0 || irq !== 1'b0) begin
            tests_failed++;
            $display("FAIL clr_plain: status0=%b irq=%b want 0/0", status_o[0], irq);
        end
        fork
            gen(100, 25, 3);
            begin
                bit found = 1'b0;
                for (int k = 0; k < 400 && !found; k++) begin
                    @(negedge clk);
                    if (valid_o === 1'b1) found = 1'b1;
                end
                tests_run++;
                if (!found) begin
                    tests_failed++;
                    $display("FAIL clr_wait: no valid_o within 400 cycles, want one");
                end else begin
                    irq_clr = 2'b01;
                    tick(1);
                    tests_run++;
                    if (status_o[0] !== 1'b1 || irq !== 1'b1) begin
                        tests_failed++;
                        $display("FAIL clr_set_wins: status0=%b irq=%b want 1/1", status_o[0], irq);
                    end
                    tick(1);
                    irq_clr = 2'b00;
                    tests_run++;
                    if (status_o[0] !== 1'b0 || irq !== 1'b0) begin
                        tests_failed++;
                        $display("FAIL clr_later: status0=%b irq=%b want 0/0", status_o[0], irq);
                    end
                end
            end
        join
        settle();
    endtask

    task automatic test_en();
        int nv0;
        nv0 = n_valid;
        drive(1'b1, 10);
        en = 1'b0;
        drive(1'b1, 5);
        en = 1'b1;
        drive(1'b1, 5);
        drive(1'b0, 30);
        drive(1'b1, 20);
        drive(1'b0, 30);
        sb.push_back('{50, 20});
        drive(1'b1, 5);
        drive(1'b0, 10);
        tests_run++;
        if (n_valid - nv0 != 1) begin
            tests_failed++;
            $display("FAIL en_count: got %0d reports want 1", n_valid - nv0);
        end
        settle();
    endtask

    task automatic test_stall();
        int n_stall = 0;
        int k_stall = -1;
        irq_en = 2'b01;
        pwm8 = 1'b1; tick(5);
        pwm8 = 1'b0; tick(15);
        pwm8 = 1'b1;
        for (int k = 1; k <= 400; k++) begin
            @(negedge clk);
            if (k == 10) irq_clr = 2'b01;
            if (k == 11) irq_clr = 2'b00;
            if (stall8 === 1'b1) begin
                n_stall++;
                if (k_stall < 0) k_stall = k;
            end
        end
        tests_run++;
        if (n_stall != 1 || k_stall != SYNC + 256) begin
            tests_failed++;
            $display("FAIL stall_pulse: got %0d pulses at cycle %0d want 1 at %0d", n_stall, k_stall, SYNC + 256);
        end
        tests_run++;
        if (period8 !== 8'd20 || high8 !== 8'd5) begin
            tests_failed++;
            $display("FAIL stall_hold: got %0d/%0d want 20/5", period8, high8);
        end
        tests_run++;
        if (status8 !== 2'b10 || irq8 !== 1'b0) begin
            tests_failed++;
            $display("FAIL stall_status: status=%b irq=%b want 10/0", status8, irq8);
        end
        irq_en = 2'b11;
        tick(1);
        tests_run++;
        if (irq8 !== 1'b1) begin
            tests_failed++;
            $display("FAIL stall_irq: irq=%b want 1", irq8);
        end
        irq_clr = 2'b10;
        tick(1);
        irq_clr = 2'b00;
        irq_en = 2'b01;
        pwm8 = 1'b0;
        settle();
    endtask

    task automatic test_reset_mid();
        int nv0;
        nv0 = n_valid;
        gen(100, 25, 2);
        drive(1'b0, 30);
        tests_run++;
        if (period_o !== 16'd100) begin
            tests_failed++;
            $display("FAIL rmid_pre: period_o=%0d want 100", period_o);
        end
        pwm = 1'b1;
        rst = 1'b1;
        tick(1);
        tests_run++;
        if ({period_o, high_o, valid_o, capture_o, stall_o, status_o, irq} !== 39'd0) begin
            tests_failed++;
            $display("FAIL rmid_reset: p=%0d h=%0d st=%b irq=%b want all 0", period_o, high_o, status_o, irq);
        end
        tick(2);
        rst = 1'b0;
        drive(1'b1, 20);
        drive(1'b0, 75);
        drive(1'b1, 25);
        drive(1'b0, 75);
        sb.push_back('{100, 25});
        drive(1'b1, 5);
        drive(1'b0, 10);
        tests_run++;
        if (n_valid - nv0 != 2) begin
            tests_failed++;
            $display("FAIL rmid_count: got %0d reports want 2", n_valid - nv0);
        end
        settle();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_duty();
        test_clr();
        test_en();
        test_stall();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire
